min_scan_unit: RTL and testbench

//   Streaming argmin engine for the sort datapath. Scans a burst of i_len elements

---
 rtl/min_scan_unit.sv | 169 ++++++++++++++++
 tb/tb_min_scan_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/min_scan_unit.sv
// ============================================================================
// min_scan_unit : streaming argmin (optional argmax) over an i_len-beat burst
// Optional feature macro: UPDATE_TRACK_MAX_EN (adds o_max_val/o_max_idx)
// Revision: 1.0
// ============================================================================
`default_nettype none

module min_scan_unit #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [IDX_W-1:0]  i_len,
  input  logic              i_abort,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_res_valid,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_min_val,
  output logic [IDX_W-1:0]  o_min_idx
`ifdef UPDATE_TRACK_MAX_EN
  ,
  output logic [DATA_W-1:0] o_max_val,
  output logic [IDX_W-1:0]  o_max_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_len;
  logic [DATA_W-1:0]   r_min_val;
  logic [IDX_W-1:0]    r_min_idx;
  logic                r_res_valid;
  logic                r_empty;
  logic                w_accept;
  logic                w_last;
  logic                w_lt;
`ifdef UPDATE_TRACK_MAX_EN
  logic [DATA_W-1:0]   r_max_val;
  logic [IDX_W-1:0]    r_max_idx;
  logic                w_gt;
`endif

  // Abort takes priority: a beat presented alongside it is discarded.
  assign w_accept = i_valid && (r_state == S_SCAN) && !i_abort;
  assign w_last   = w_accept && (r_cnt == (r_len - IDX_W'(1)));

  generate
    if (SIGNED) begin : g_signed
      assign w_lt = $signed(i_data) < $signed(r_min_val);
`ifdef UPDATE_TRACK_MAX_EN
      assign w_gt = $signed(i_data) > $signed(r_max_val);
`endif
    end else begin : g_unsigned
      assign w_lt = i_data < r_min_val;
`ifdef UPDATE_TRACK_MAX_EN
      assign w_gt = i_data > r_max_val;
`endif
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_busy  = 1'b1;
    o_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = (i_len == '0) ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        o_ready = 1'b1;
        if (i_abort)     w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_len       <= '0;
      r_min_val   <= '0;
      r_min_idx   <= '0;
      r_res_valid <= 1'b0;
      r_empty     <= 1'b0;
`ifdef UPDATE_TRACK_MAX_EN
      r_max_val   <= '0;
      r_max_idx   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len <= i_len;
            r_cnt <= '0;
            if (i_len == '0) begin
              r_min_val   <= '0;
              r_min_idx   <= '0;
              r_empty     <= 1'b1;
              r_res_valid <= 1'b1;
`ifdef UPDATE_TRACK_MAX_EN
              r_max_val   <= '0;
              r_max_idx   <= '0;
`endif
            end else begin
              r_empty     <= 1'b0;
              r_res_valid <= 1'b0;
            end
          end
        end
        S_SCAN: begin
          if (w_accept) begin
            r_cnt <= r_cnt + IDX_W'(1);
            // Strict compares keep the first occurrence on ties.
            if ((r_cnt == '0) || w_lt) begin
              r_min_val <= i_data;
              r_min_idx <= r_cnt;
            end
`ifdef UPDATE_TRACK_MAX_EN
            if ((r_cnt == '0) || w_gt) begin
              r_max_val <= i_data;
              r_max_idx <= r_cnt;
            end
`endif
            if (w_last) r_res_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_empty     = r_empty;
  assign o_min_val   = r_min_val;
  assign o_min_idx   = r_min_idx;
`ifdef UPDATE_TRACK_MAX_EN
  assign o_max_val   = r_max_val;
  assign o_max_idx   = r_max_idx;
`endif

endmodule

`default_nettype wire

// File: tb/tb_min_scan_unit.sv
// Directed self-checking bench for min_scan_unit (unsigned and signed instances).
`default_nettype none

module tb_min_scan_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       valid;
  logic [7:0] data;

  logic       u_ready, u_busy, u_done, u_res_valid, u_empty;
  logic [7:0] u_min_val, u_min_idx;
  logic       s_ready, s_busy, s_done, s_res_valid, s_empty;
  logic [7:0] s_min_val, s_min_idx;
`ifdef UPDATE_TRACK_MAX_EN
  logic [7:0] u_max_val, u_max_idx, s_max_val, s_max_idx;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  min_scan_unit #(.DATA_W(8), .IDX_W(8), .SIGNED(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_abort(abort),
    .i_valid(valid), .o_ready(u_ready), .i_data(data), .o_busy(u_busy), .o_done(u_done),
    .o_res_valid(u_res_valid), .o_empty(u_empty), .o_min_val(u_min_val), .o_min_idx(u_min_idx)
`ifdef UPDATE_TRACK_MAX_EN
    , .o_max_val(u_max_val), .o_max_idx(u_max_idx)
`endif
  );

  min_scan_unit #(.DATA_W(8), .IDX_W(8), .SIGNED(1'b1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_abort(abort),
    .i_valid(valid), .o_ready(s_ready), .i_data(data), .o_busy(s_busy), .o_done(s_done),
    .o_res_valid(s_res_valid), .o_empty(s_empty), .o_min_val(s_min_val), .o_min_idx(s_min_idx)
`ifdef UPDATE_TRACK_MAX_EN
    , .o_max_val(s_max_val), .o_max_idx(s_max_idx)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l, input logic ab);
    start = 1'b1; len = l; abort = ab;
    tick();
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    valid = 1'b1; data = d;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; len = 8'd3; valid = 1'b1; data = 8'h11;
    tick(); tick();
    checks++; if (u_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b exp 0", u_busy); end
    checks++; if (u_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %0b exp 0", u_ready); end
    checks++; if (u_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b exp 0", u_done); end
    checks++; if ({u_res_valid, u_empty, u_min_val, u_min_idx} !== 18'd0) begin fails++; $display("FAIL rst_results: got %0h exp 0", {u_res_valid, u_empty, u_min_val, u_min_idx}); end
    start = 1'b0; valid = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if (u_busy !== 1'b0) begin fails++; $display("FAIL rst_idle_after: got %0b exp 0", u_busy); end
  endtask

  task automatic test_basic();
    do_start(8'd5, 1'b0);
    checks++; if (u_ready !== 1'b1) begin fails++; $display("FAIL t1_ready: got %0b exp 1", u_ready); end
    checks++; if (u_res_valid !== 1'b0) begin fails++; $display("FAIL t1_resv_clr: got %0b exp 0", u_res_valid); end
    beat(8'd7); beat(8'd3); beat(8'd9); beat(8'd3);
    checks++; if (u_done !== 1'b0) begin fails++; $display("FAIL t1_early_done: got %0b exp 0", u_done); end
    beat(8'd1);
    checks++; if (u_done !== 1'b1) begin fails++; $display("FAIL t1_done: got %0b exp 1", u_done); end
    checks++; if (u_res_valid !== 1'b1) begin fails++; $display("FAIL t1_resv: got %0b exp 1", u_res_valid); end
    checks++; if (u_min_val !== 8'd1) begin fails++; $display("FAIL t1_min: got %0d exp 1", u_min_val); end
    checks++; if (u_min_idx !== 8'd4) begin fails++; $display("FAIL t1_idx: got %0d exp 4", u_min_idx); end
    checks++; if (s_min_idx !== 8'd4) begin fails++; $display("FAIL t1_s_idx: got %0d exp 4", s_min_idx); end
`ifdef UPDATE_TRACK_MAX_EN
    checks++; if ({u_max_val, u_max_idx} !== {8'd9, 8'd2}) begin fails++; $display("FAIL t1_max: got %0h exp 0902", {u_max_val, u_max_idx}); end
`endif
    tick();
    checks++; if (u_done !== 1'b0 || u_busy !== 1'b0) begin fails++; $display("FAIL t1_pulse: got done=%0b busy=%0b exp 0 0", u_done, u_busy); end
    checks++; if (u_min_val !== 8'd1 || u_res_valid !== 1'b1) begin fails++; $display("FAIL t1_hold: got min=%0d resv=%0b exp 1 1", u_min_val, u_res_valid); end
  endtask

  task automatic test_stalls();
    logic [7:0] v [4] = '{8'd5, 8'd2, 8'd2, 8'd8};
    do_start(8'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat(v[i]);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) tick();
        checks++; if (u_done !== 1'b0 || u_busy !== 1'b1) begin fails++; $display("FAIL t2_gap%0d: got done=%0b busy=%0b exp 0 1", i, u_done, u_busy); end
      end
    end
    checks++; if (u_done !== 1'b1) begin fails++; $display("FAIL t2_done: got %0b exp 1", u_done); end
    checks++; if ({u_min_val, u_min_idx} !== {8'd2, 8'd1}) begin fails++; $display("FAIL t2_min: got %0h exp 0201", {u_min_val, u_min_idx}); end
`ifdef UPDATE_TRACK_MAX_EN
    checks++; if ({u_max_val, u_max_idx} !== {8'd8, 8'd3}) begin fails++; $display("FAIL t2_max: got %0h exp 0803", {u_max_val, u_max_idx}); end
`endif
    tick();
  endtask

  task automatic test_empty();
    do_start(8'd0, 1'b0);
    checks++; if (u_done !== 1'b1) begin fails++; $display("FAIL t3_done: got %0b exp 1", u_done); end
    checks++; if (u_empty !== 1'b1 || u_res_valid !== 1'b1) begin fails++; $display("FAIL t3_flags: got empty=%0b resv=%0b exp 1 1", u_empty, u_res_valid); end
    checks++; if ({u_min_val, u_min_idx} !== 16'd0) begin fails++; $display("FAIL t3_min: got %0h exp 0", {u_min_val, u_min_idx}); end
`ifdef UPDATE_TRACK_MAX_EN
    checks++; if ({u_max_val, u_max_idx} !== 16'd0) begin fails++; $display("FAIL t3_max: got %0h exp 0", {u_max_val, u_max_idx}); end
`endif
    tick();
    checks++; if (u_busy !== 1'b0 || u_done !== 1'b0) begin fails++; $display("FAIL t3_idle: got busy=%0b done=%0b exp 0 0", u_busy, u_done); end
  endtask

  task automatic test_signed();
    do_start(8'd3, 1'b0);
    checks++; if (u_empty !== 1'b0) begin fails++; $display("FAIL t4_empty_clr: got %0b exp 0", u_empty); end
    beat(8'h05); beat(8'hFE); beat(8'h80);
    checks++; if ({u_min_val, u_min_idx} !== {8'h05, 8'd0}) begin fails++; $display("FAIL t4_unsigned: got %0h exp 0500", {u_min_val, u_min_idx}); end
    checks++; if ({s_min_val, s_min_idx} !== {8'h80, 8'd2}) begin fails++; $display("FAIL t4_signed: got %0h exp 8002", {s_min_val, s_min_idx}); end
    checks++; if (s_done !== 1'b1) begin fails++; $display("FAIL t4_s_done: got %0b exp 1", s_done); end
`ifdef UPDATE_TRACK_MAX_EN
    checks++; if ({u_max_val, u_max_idx} !== {8'hFE, 8'd1}) begin fails++; $display("FAIL t4_umax: got %0h exp FE01", {u_max_val, u_max_idx}); end
    checks++; if ({s_max_val, s_max_idx} !== {8'h05, 8'd0}) begin fails++; $display("FAIL t4_smax: got %0h exp 0500", {s_max_val, s_max_idx}); end
`endif
    tick();
  endtask

  task automatic test_abort();
    do_start(8'd6, 1'b0);
    beat(8'd9); beat(8'd8);
    abort = 1'b1; valid = 1'b1; data = 8'd0;
    tick();
    abort = 1'b0; valid = 1'b0;
    checks++; if (u_busy !== 1'b0 || u_done !== 1'b0) begin fails++; $display("FAIL t5_abort: got busy=%0b done=%0b exp 0 0", u_busy, u_done); end
    checks++; if (u_res_valid !== 1'b0) begin fails++; $display("FAIL t5_resv: got %0b exp 0", u_res_valid); end
    tick();
    checks++; if (u_done !== 1'b0) begin fails++; $display("FAIL t5_nodone: got %0b exp 0", u_done); end
    do_start(8'd1, 1'b1);
    checks++; if (u_busy !== 1'b1) begin fails++; $display("FAIL t5_start_wins: got %0b exp 1", u_busy); end
    beat(8'd4);
    checks++; if (u_done !== 1'b1 || u_res_valid !== 1'b1) begin fails++; $display("FAIL t5_done: got done=%0b resv=%0b exp 1 1", u_done, u_res_valid); end
    checks++; if ({u_min_val, u_min_idx} !== {8'd4, 8'd0}) begin fails++; $display("FAIL t5_min: got %0h exp 0400", {u_min_val, u_min_idx}); end
    tick();
  endtask

  task automatic test_busy_start_and_reset();
    do_start(8'd3, 1'b0);
    beat(8'd9);
    start = 1'b1; len = 8'd1;
    beat(8'd4);
    start = 1'b0;
    checks++; if (u_done !== 1'b0 || u_busy !== 1'b1) begin fails++; $display("FAIL t6_stray: got done=%0b busy=%0b exp 0 1", u_done, u_busy); end
    beat(8'd6);
    checks++; if (u_done !== 1'b1) begin fails++; $display("FAIL t6_len_kept: got %0b exp 1", u_done); end
    checks++; if ({u_min_val, u_min_idx} !== {8'd4, 8'd1}) begin fails++; $display("FAIL t6_min: got %0h exp 0401", {u_min_val, u_min_idx}); end
    tick();
    do_start(8'd5, 1'b0);
    beat(8'd2); beat(8'd3);
    rst_n = 1'b0; start = 1'b1; len = 8'd0; valid = 1'b1; data = 8'd1;
    tick();
    checks++; if ({u_busy, u_ready, u_done, u_res_valid, u_empty} !== 5'd0) begin fails++; $display("FAIL t6_rst_ctl: got %0b exp 0", {u_busy, u_ready, u_done, u_res_valid, u_empty}); end
    checks++; if ({u_min_val, u_min_idx} !== 16'd0) begin fails++; $display("FAIL t6_rst_min: got %0h exp 0", {u_min_val, u_min_idx}); end
    checks++; if ({s_busy, s_ready, s_done, s_res_valid, s_empty, s_min_val, s_min_idx} !== 21'd0) begin fails++; $display("FAIL t6_rst_s: got %0h exp 0", {s_busy, s_ready, s_done, s_res_valid, s_empty, s_min_val, s_min_idx}); end
`ifdef UPDATE_TRACK_MAX_EN
    checks++; if ({u_max_val, u_max_idx} !== 16'd0) begin fails++; $display("FAIL t6_rst_max: got %0h exp 0", {u_max_val, u_max_idx}); end
`endif
    start = 1'b0; valid = 1'b0; rst_n = 1'b1;
    tick(); tick();
    checks++; if (u_busy !== 1'b0 || u_done !== 1'b0) begin fails++; $display("FAIL t6_idle: got busy=%0b done=%0b exp 0 0", u_busy, u_done); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0; valid = 1'b0; data = '0;
    test_reset();
    test_basic();
    test_stalls();
    test_empty();
    test_signed();
    test_abort();
    test_busy_start_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
